// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator processor: field widths, opcode
// encoding and the instruction-fetch FSM state encoding.
package cpu_pkg;

    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_OPC_W   = 3;
    localparam int DEF_INSTR_W = DEF_OPC_W + DEF_ADDR_W;

    localparam logic [2:0] OP_LDA  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_NOT  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_XNOR = 3'b110;
    localparam logic [2:0] OP_JMP  = 3'b111;

    localparam logic [1:0] FS_IDLE  = 2'd0;
    localparam logic [1:0] FS_REQ   = 2'd1;
    localparam logic [1:0] FS_ISSUE = 2'd2;

    // pc_src without jmp_uncond is reserved for conditional branches and
    // currently falls through to the sequential path.
    function automatic logic take_jump(input logic pc_src, input logic jmp_uncond);
        return pc_src & jmp_uncond;
    endfunction

endpackage

// File: rtl/fetch_pc_counter.sv
// Program counter register: a jump target load takes priority over the
// sequential increment, which wraps modulo 2^ADDR_W.
module fetch_pc_counter
    import cpu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] target,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests the word at pc, registers opcode/operand
// for the controller and steps pc (sequential or jump) when execution accepts.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int OPC_W   = DEF_OPC_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ack,
    output logic [OPC_W-1:0]   opcode,
    output logic [ADDR_W-1:0]  operand,
    output logic               instr_valid,
    input  logic               exec_ready,
    input  logic               pc_src,
    input  logic               jmp_uncond,
    output logic [ADDR_W-1:0]  pc
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       fetch_done;
    logic       accept;
    logic       jump;

    // Handshakes: a memory read completes on the edge where imem_req and
    // imem_ack are both high; an instruction is accepted on the edge where
    // instr_valid and exec_ready are both high. Neither side withdraws.
    assign fetch_done = (state == FS_REQ) && imem_ack;
    assign accept     = (state == FS_ISSUE) && exec_ready;
    assign jump       = accept && take_jump(pc_src, jmp_uncond);

    always_comb begin
        state_nxt = state;
        case (state)
            FS_IDLE:  if (en) state_nxt = FS_REQ;
            FS_REQ:   if (imem_ack) state_nxt = FS_ISSUE;
            FS_ISSUE: if (exec_ready) state_nxt = en ? FS_REQ : FS_IDLE;
            default:  state_nxt = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode  <= '0;
            operand <= '0;
        end else if (fetch_done) begin
            opcode  <= imem_rdata[INSTR_W-1 -: OPC_W];
            operand <= imem_rdata[ADDR_W-1:0];
        end
    end

    // Address is forced to zero outside REQ so the bus is quiet when idle.
    assign imem_req    = (state == FS_REQ);
    assign imem_addr   = imem_req ? pc : '0;
    assign instr_valid = (state == FS_ISSUE);

    fetch_pc_counter #(
        .ADDR_W (ADDR_W)
    ) u_pc (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (jump),
        .target (operand),
        .inc    (accept && !jump),
        .pc     (pc)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed sequences, a vector
// table of single instructions, and randomized runs against a program model.
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    localparam int AW = 5;
    localparam int OW = 3;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    logic          imem_ack;
    logic [OW-1:0] opcode;
    logic [AW-1:0] operand;
    logic          instr_valid;
    logic          exec_ready;
    logic          pc_src;
    logic          jmp_uncond;
    logic [AW-1:0] pc;

    logic          auto_ctrl;
    logic          man_src;
    logic          man_jmp;
    logic          man_ack;
    logic          auto_ack;
    logic [IW-1:0] rdata_r;
    int            mem_wait;
    int            wcnt;
    logic [IW-1:0] mem [32];

    logic          mon_en;
    logic [AW-1:0] model_pc;
    logic [AW-1:0] exp_q[$];
    int            n_fetch;
    logic          prev_req;
    logic [AW-1:0] prev_addr;
    logic          prev_valid;
    logic [OW-1:0] prev_opc;
    logic [AW-1:0] prev_opr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] word;
        logic       src;
        logic       jmp;
        logic [2:0] opc;
        logic [4:0] opr;
        logic [4:0] nxt;
    } vec_t;
    vec_t tbl [11];

    always #5 clk = ~clk;

    // Controller stand-in: JMP is unconditional, SUB raises pc_src alone.
    assign pc_src     = auto_ctrl ? ((opcode == OP_JMP) || (opcode == OP_SUB)) : man_src;
    assign jmp_uncond = auto_ctrl ? (opcode == OP_JMP) : man_jmp;
    assign imem_ack   = auto_ack | man_ack;
    assign imem_rdata = rdata_r;

    instr_fetch_unit #(.ADDR_W(AW), .OPC_W(OW), .INSTR_W(IW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .opcode      (opcode),
        .operand     (operand),
        .instr_valid (instr_valid),
        .exec_ready  (exec_ready),
        .pc_src      (pc_src),
        .jmp_uncond  (jmp_uncond),
        .pc          (pc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (instr_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, instr_valid}, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        exec_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Memory responder: acks after mem_wait stall cycles of an asserted request.
    initial begin
        auto_ack = 1'b0;
        rdata_r  = '0;
        wcnt     = 0;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                if (wcnt >= mem_wait) begin
                    auto_ack = 1'b1;
                    rdata_r  = mem[imem_addr];
                    wcnt     = 0;
                end else begin
                    auto_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                auto_ack = 1'b0;
                wcnt     = 0;
            end
        end
    end

    // Program-level reference: each completed fetch must come from the
    // predicted address; each acceptance advances the predicted pc.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (prev_req && imem_ack) begin
                logic [AW-1:0] ea;
                logic [7:0]    w;
                n_fetch++;
                if (exp_q.size() == 0) begin
                    check("rand_queue_empty", 32'd0, 32'd1);
                end else begin
                    ea = exp_q.pop_front();
                    w  = mem[ea];
                    check("rand_fetch_addr", {27'd0, prev_addr}, {27'd0, ea});
                    check("rand_opcode", {29'd0, opcode}, {29'd0, w[7:5]});
                    check("rand_operand", {27'd0, operand}, {27'd0, w[4:0]});
                end
            end
            if (prev_valid && exec_ready) begin
                model_pc = (prev_opc == OP_JMP) ? prev_opr : AW'((int'(model_pc) + 1) % 32);
                exp_q.push_back(model_pc);
            end
            check("rand_pc", {27'd0, pc}, {27'd0, model_pc});
        end
        prev_req   = imem_req;
        prev_addr  = imem_addr;
        prev_valid = instr_valid;
        prev_opc   = opcode;
        prev_opr   = operand;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; exec_ready = 1'b0;
        man_src = 1'b0; man_jmp = 1'b0; man_ack = 1'b0; auto_ctrl = 1'b0;
        mem_wait = 0; mon_en = 1'b0; n_fetch = 0; model_pc = '0;
        for (int i = 0; i < 32; i++) mem[i] = '0;

        tbl[0]  = '{8'h05, 1'b0, 1'b0, 3'd0, 5'd5,  5'd1};
        tbl[1]  = '{8'h2A, 1'b0, 1'b0, 3'd1, 5'd10, 5'd2};
        tbl[2]  = '{8'h43, 1'b0, 1'b0, 3'd2, 5'd3,  5'd3};
        tbl[3]  = '{8'hE7, 1'b1, 1'b1, 3'd7, 5'd7,  5'd7};
        tbl[4]  = '{8'hF4, 1'b1, 1'b1, 3'd7, 5'd20, 5'd20};
        tbl[5]  = '{8'hE7, 1'b1, 1'b1, 3'd7, 5'd7,  5'd7};
        tbl[6]  = '{8'hF4, 1'b1, 1'b0, 3'd7, 5'd20, 5'd8};
        tbl[7]  = '{8'hFF, 1'b1, 1'b1, 3'd7, 5'd31, 5'd31};
        tbl[8]  = '{8'h60, 1'b0, 1'b0, 3'd3, 5'd0,  5'd0};
        tbl[9]  = '{8'hE0, 1'b1, 1'b1, 3'd7, 5'd0,  5'd0};
        tbl[10] = '{8'hE0, 1'b0, 1'b0, 3'd7, 5'd0,  5'd1};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_pc", {27'd0, pc}, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", {27'd0, imem_addr}, 32'd0);
        check("rst_opcode", {29'd0, opcode}, 32'd0);
        check("rst_operand", {27'd0, operand}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        rst_n = 1'b1;

        // Zero-wait throughput: REQ/ISSUE alternate, one instruction per 2 cycles
        mem[0] = 8'h05; mem[1] = 8'h2A; mem[2] = 8'h43;
        en = 1'b1; exec_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("tp_req", {31'd0, imem_req}, {31'd0, k[0]});
            check("tp_valid", {31'd0, instr_valid}, {31'd0, ~k[0]});
            if (k % 2 == 1) begin
                check("tp_addr", {27'd0, imem_addr}, (k - 1) / 2);
            end else begin
                logic [7:0] w;
                w = mem[(k - 2) / 2];
                check("tp_opcode", {29'd0, opcode}, {29'd0, w[7:5]});
                check("tp_operand", {27'd0, operand}, {27'd0, w[4:0]});
            end
        end
        do_reset();

        // Three wait states, then a 5-cycle execution stall
        mem[0] = 8'hB3; mem[1] = 8'h6D; mem[2] = 8'h00;
        mem_wait = 3; en = 1'b1; exec_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("ws_req", {31'd0, imem_req}, 32'd1);
            check("ws_addr", {27'd0, imem_addr}, 32'd0);
            check("ws_valid", {31'd0, instr_valid}, 32'd0);
            check("ws_pc", {27'd0, pc}, 32'd0);
        end
        for (int k = 5; k <= 9; k++) begin
            @(negedge clk);
            check("st_valid", {31'd0, instr_valid}, 32'd1);
            check("st_req", {31'd0, imem_req}, 32'd0);
            check("st_opcode", {29'd0, opcode}, 32'd5);
            check("st_operand", {27'd0, operand}, 32'h13);
            check("st_pc", {27'd0, pc}, 32'd0);
        end
        exec_ready = 1'b1; mem_wait = 0;
        @(negedge clk);
        check("st_pc_step", {27'd0, pc}, 32'd1);
        check("st_next_req", {31'd0, imem_req}, 32'd1);
        check("st_next_addr", {27'd0, imem_addr}, 32'd1);
        // en dropped while the request is in flight
        exec_ready = 1'b0; en = 1'b0;
        @(negedge clk);
        check("en_valid", {31'd0, instr_valid}, 32'd1);
        check("en_opcode", {29'd0, opcode}, 32'd3);
        check("en_operand", {27'd0, operand}, 32'h0D);
        check("en_pc_hold", {27'd0, pc}, 32'd1);
        exec_ready = 1'b1;
        @(negedge clk);
        exec_ready = 1'b0;
        check("en_idle_valid", {31'd0, instr_valid}, 32'd0);
        check("en_idle_req", {31'd0, imem_req}, 32'd0);
        check("en_idle_pc", {27'd0, pc}, 32'd2);
        @(negedge clk);
        check("en_park_req", {31'd0, imem_req}, 32'd0);
        check("en_park_pc", {27'd0, pc}, 32'd2);

        // Reset in the middle of an outstanding read, then a stray ack
        mem_wait = 10; en = 1'b1;
        @(negedge clk);
        check("mr_req", {31'd0, imem_req}, 32'd1);
        check("mr_addr", {27'd0, imem_addr}, 32'd2);
        @(negedge clk);
        rst_n = 1'b0; en = 1'b0;
        #1;
        check("mr_rst_pc", {27'd0, pc}, 32'd0);
        check("mr_rst_req", {31'd0, imem_req}, 32'd0);
        check("mr_rst_addr", {27'd0, imem_addr}, 32'd0);
        check("mr_rst_opcode", {29'd0, opcode}, 32'd0);
        check("mr_rst_operand", {27'd0, operand}, 32'd0);
        check("mr_rst_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("mr_late_valid", {31'd0, instr_valid}, 32'd0);
            check("mr_late_opcode", {29'd0, opcode}, 32'd0);
            check("mr_late_req", {31'd0, imem_req}, 32'd0);
            @(negedge clk);
        end
        mem_wait = 0;
        do_reset();

        // Vector table: one instruction per row, stepped by a single-cycle ready
        mem[0] = tbl[0].word; en = 1'b1; exec_ready = 1'b0;
        wait_valid("tbl_first_valid");
        for (int i = 0; i < 11; i++) begin
            check("tbl_opcode", {29'd0, opcode}, {29'd0, tbl[i].opc});
            check("tbl_operand", {27'd0, operand}, {27'd0, tbl[i].opr});
            if (i < 10) mem[tbl[i].nxt] = tbl[i + 1].word;
            man_src = tbl[i].src; man_jmp = tbl[i].jmp;
            exec_ready = 1'b1;
            @(negedge clk);
            exec_ready = 1'b0; man_src = 1'b0; man_jmp = 1'b0;
            check("tbl_next_req", {31'd0, imem_req}, 32'd1);
            check("tbl_next_addr", {27'd0, imem_addr}, {27'd0, tbl[i].nxt});
            check("tbl_next_pc", {27'd0, pc}, {27'd0, tbl[i].nxt});
            wait_valid("tbl_valid");
        end
        do_reset();

        // Randomized program with random stalls, wait states and en drops
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom_range(0, 255));
        model_pc = '0;
        exp_q.delete();
        exp_q.push_back('0);
        n_fetch = 0;
        auto_ctrl = 1'b1;
        mon_en = 1'b1;
        repeat (3000) begin
            @(negedge clk);
            en = ($urandom_range(0, 7) != 0);
            exec_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mem_wait = $urandom_range(0, 3);
        end
        @(negedge clk);
        mon_en = 1'b0;
        check("rand_activity", {31'd0, n_fetch > 200}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
